// File: rtl/vga_frame_scanout.sv
// vga_frame_scanout
//   Read side of a (IMG_W x IMG_H) frame buffer. Generates 640x480@60 VGA
//   timing from CLOCK_50 with a /2 pixel tick. Every stored pixel is shown 2x2.
//   The RAM read port is driven here, and the 1-cycle RAM latency is absorbed
//   into a fixed 3-stage pipeline. Syncs, BLANK_N and RGB leave aligned.
//
//   Ports:
//     CLOCK_50, RESET           clock, async active-high reset
//     fb_addr/fb_en/fb_write    RAM read port (write strobe tied 0)
//     fb_data                   RAM out_data, valid 1 clock after fb_addr/fb_en
//     VGA_CLK                   25 MHz pixel clock (tick phase)
//     VGA_HS/VS                 active-low syncs
//     VGA_BLANK_N, VGA_SYNC_N   active video / tied 0
//     VGA_R/G/B                 colour, forced 0 outside active video
//     VBLANK, FRAME_START       tear-free update hints for the writer
//
//   Build option: define SCANOUT_RGB332_EN to decode pixels as RRRGGGBB.
//   Without it the output is greyscale (R=G=B=pixel).
module vga_frame_scanout #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 20,
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_en,
  output logic                  fb_write,
  input  logic [DATA_WIDTH-1:0] fb_data,
  output logic                  VGA_CLK,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_BLANK_N,
  output logic                  VGA_SYNC_N,
  output logic [7:0]            VGA_R,
  output logic [7:0]            VGA_G,
  output logic [7:0]            VGA_B,
  output logic                  VBLANK,
  output logic                  FRAME_START
);

  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(2 * IMG_W);
  localparam logic [HW-1:0] H_SYNC0 = HW'(2 * IMG_W + 16);
  localparam logic [HW-1:0] H_SYNC1 = HW'(2 * IMG_W + 16 + 96);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(2 * IMG_H);
  localparam logic [VW-1:0] V_SYNC0 = VW'(2 * IMG_H + 10);
  localparam logic [VW-1:0] V_SYNC1 = VW'(2 * IMG_H + 10 + 2);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(IMG_W);

  // Timing state
  logic                  phase_q, phase_d;
  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic [VW-1:0]         v_cnt_q, v_cnt_d;
  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
  logic                  wrap_q, wrap_d;
  // S1
  logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic                  fb_en_q, fb_en_d;
  logic                  hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d, vb1_q, vb1_d, fs1_q, fs1_d;
  // S2
  logic                  hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d, vb2_q, vb2_d, fs2_q, fs2_d;
  // S3
  logic                  hs3_q, hs3_d, vs3_q, vs3_d, de3_q, de3_d, vb3_q, vb3_d, fs3_q, fs3_d;
  logic [7:0]            r_q, r_d, g_q, g_d, b_q, b_d;

  logic       tick, h_last, v_last, active;
  logic [7:0] pix;

  always_comb begin
    tick   = phase_q;
    h_last = (h_cnt_q == H_LAST);
    v_last = (v_cnt_q == V_LAST);
    active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    pix    = 8'(fb_data);

    phase_d     = ~phase_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    line_base_d = line_base_q;
    wrap_d      = tick && h_last && v_last;

    if (tick) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
      if (h_last) begin
        v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        // Each stored line is shown twice, so the base advances after odd lines.
        if (v_last)
          line_base_d = '0;
        else if (v_cnt_q[0] && (v_cnt_q < V_ACT))
          line_base_d = line_base_q + LINE_STEP;
      end
    end

    // S1: address the RAM and register the raw timing flags.
    fb_en_d   = active;
    fb_addr_d = active ? line_base_q + ADDR_WIDTH'(h_cnt_q[HW-1:1]) : fb_addr_q;
    hs1_d     = !((h_cnt_q >= H_SYNC0) && (h_cnt_q < H_SYNC1));
    vs1_d     = !((v_cnt_q >= V_SYNC0) && (v_cnt_q < V_SYNC1));
    de1_d     = active;
    vb1_d     = (v_cnt_q >= V_ACT);
    fs1_d     = wrap_q;

    // S2: the RAM registers fb_data during this stage.
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    de2_d = de1_q;
    vb2_d = vb1_q;
    fs2_d = fs1_q;

    // S3: output registers.
    hs3_d = hs2_q;
    vs3_d = vs2_q;
    de3_d = de2_q;
    vb3_d = vb2_q;
    fs3_d = fs2_q;
`ifdef SCANOUT_RGB332_EN
    r_d = de2_q ? {pix[7:5], pix[7:5], pix[7:6]} : '0;
    g_d = de2_q ? {pix[4:2], pix[4:2], pix[4:3]} : '0;
    b_d = de2_q ? {pix[1:0], pix[1:0], pix[1:0], pix[1:0]} : '0;
`else
    r_d = de2_q ? pix : '0;
    g_d = de2_q ? pix : '0;
    b_d = de2_q ? pix : '0;
`endif
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      phase_q     <= 1'b0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      line_base_q <= '0;
      wrap_q      <= 1'b0;
      fb_addr_q   <= '0;
      fb_en_q     <= 1'b0;
      // Sync stages reset to the inactive (high) level so no glitch leaks out.
      hs1_q <= 1'b1; vs1_q <= 1'b1; de1_q <= 1'b0; vb1_q <= 1'b0; fs1_q <= 1'b0;
      hs2_q <= 1'b1; vs2_q <= 1'b1; de2_q <= 1'b0; vb2_q <= 1'b0; fs2_q <= 1'b0;
      hs3_q <= 1'b1; vs3_q <= 1'b1; de3_q <= 1'b0; vb3_q <= 1'b0; fs3_q <= 1'b0;
      r_q <= '0; g_q <= '0; b_q <= '0;
    end else begin
      phase_q     <= phase_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      line_base_q <= line_base_d;
      wrap_q      <= wrap_d;
      fb_addr_q   <= fb_addr_d;
      fb_en_q     <= fb_en_d;
      hs1_q <= hs1_d; vs1_q <= vs1_d; de1_q <= de1_d; vb1_q <= vb1_d; fs1_q <= fs1_d;
      hs2_q <= hs2_d; vs2_q <= vs2_d; de2_q <= de2_d; vb2_q <= vb2_d; fs2_q <= fs2_d;
      hs3_q <= hs3_d; vs3_q <= vs3_d; de3_q <= de3_d; vb3_q <= vb3_d; fs3_q <= fs3_d;
      r_q <= r_d; g_q <= g_d; b_q <= b_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign fb_en       = fb_en_q;
  assign fb_write    = 1'b0;
  assign VGA_CLK     = phase_q;
  assign VGA_HS      = hs3_q;
  assign VGA_VS      = vs3_q;
  assign VGA_BLANK_N = de3_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VBLANK      = vb3_q;
  assign FRAME_START = fs3_q;

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Bench for vga_frame_scanout on a shrunken raster (64x8 active, same porches
// and sync widths) so that several whole frames fit in a short run.
module tb_vga_frame_scanout;

  localparam int IMG_W = 32;
  localparam int IMG_H = 4;
  localparam int HA    = 2 * IMG_W;
  localparam int VA    = 2 * IMG_H;
  localparam int HT    = HA + 16 + 96 + 48;
  localparam int VT    = VA + 10 + 2 + 33;
  localparam int HSS   = HA + 16;
  localparam int HSE   = HSS + 96;
  localparam int VSS   = VA + 10;
  localparam int VSE   = VSS + 2;
  localparam int NPIX  = HT * VT;
  localparam int MEMSZ = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] fb_addr;
  logic        fb_en, fb_write;
  logic [7:0]  fb_data = '0;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vblank, frame_start;

  vga_frame_scanout #(
    .DATA_WIDTH(8), .ADDR_WIDTH(20), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .H_TOTAL(HT), .V_TOTAL(VT)
  ) dut (
    .CLOCK_50(clk), .RESET(rst),
    .fb_addr(fb_addr), .fb_en(fb_en), .fb_write(fb_write), .fb_data(fb_data),
    .VGA_CLK(vga_clk), .VGA_HS(vga_hs), .VGA_VS(vga_vs),
    .VGA_BLANK_N(vga_blank_n), .VGA_SYNC_N(vga_sync_n),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VBLANK(vblank), .FRAME_START(frame_start)
  );

  always #5 clk = ~clk;

  // Frame-buffer RAM: 1-cycle read latency; junk on the bus when not enabled.
  logic [7:0] mem [MEMSZ];
  always @(posedge clk) begin
    if (fb_en) begin
      if (int'(fb_addr) < MEMSZ) fb_data <= mem[int'(fb_addr)];
      else                       fb_data <= 8'hEE;
    end else begin
      fb_data <= 8'($urandom);
    end
  end

  int checks = 0;
  int errors = 0;
  int unsigned k;          // posedges since the last reset release
  logic [19:0] last_addr;
  logic        exp_en;
  int fs_seen, fs_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [23:0] colour(input logic [7:0] p);
`ifdef SCANOUT_RGB332_EN
    return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3],
            p[1:0], p[1:0], p[1:0], p[1:0]};
`else
    return {p, p, p};
`endif
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_addr"}, 32'(fb_addr), 0);
    chk({tag, "_en"}, 32'(fb_en), 0);
    chk({tag, "_vclk"}, 32'(vga_clk), 0);
    chk({tag, "_hs"}, 32'(vga_hs), 1);
    chk({tag, "_vs"}, 32'(vga_vs), 1);
    chk({tag, "_blank_n"}, 32'(vga_blank_n), 0);
    chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 0);
    chk({tag, "_vblank"}, 32'(vblank), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  // Expected state after posedge k, derived from the global pixel count.
  task automatic check_cycle();
    int unsigned p, h, v, p1, h1, v1;
    logic e_hs, e_vs, e_bn, e_vb, e_fs, act;
    logic [23:0] e_rgb;
    logic [19:0] e_addr;

    // Read port: one register after the counter state of edge k-1.
    p1 = (k - 1) / 2;
    h1 = p1 % HT;
    v1 = (p1 / HT) % VT;
    exp_en = (h1 < HA) && (v1 < VA);
    if (exp_en) begin
      e_addr    = 20'((v1 / 2) * IMG_W + h1 / 2);
      last_addr = e_addr;
    end else begin
      e_addr = last_addr;
    end

    // Pins: three registers after the counter state of edge k-3.
    if (k < 3) begin
      e_hs = 1; e_vs = 1; e_bn = 0; e_vb = 0; e_fs = 0; e_rgb = '0;
    end else begin
      p   = (k - 3) / 2;
      h   = p % HT;
      v   = (p / HT) % VT;
      act = (h < HA) && (v < VA);
      e_hs  = !(h >= HSS && h < HSE);
      e_vs  = !(v >= VSS && v < VSE);
      e_bn  = act;
      e_vb  = (v >= VA);
      e_fs  = (((k - 3) % 2) == 0) && (p > 0) && ((p % NPIX) == 0);
      e_rgb = act ? colour(mem[(v / 2) * IMG_W + h / 2]) : '0;
    end

    chk("fb_en", 32'(fb_en), 32'(exp_en));
    chk("fb_addr", 32'(fb_addr), 32'(e_addr));
    chk("fb_write", 32'(fb_write), 0);
    chk("vga_clk", 32'(vga_clk), 32'(k % 2));
    chk("hs", 32'(vga_hs), 32'(e_hs));
    chk("vs", 32'(vga_vs), 32'(e_vs));
    chk("blank_n", 32'(vga_blank_n), 32'(e_bn));
    chk("sync_n", 32'(vga_sync_n), 0);
    chk("vblank", 32'(vblank), 32'(e_vb));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    if (frame_start === 1'b1) fs_seen++;
    if (e_fs) fs_exp++;
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    #1;
    check_cycle();
  endtask

  initial begin
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    mem[5] = 8'hA7;
    k = 0; last_addr = '0; fs_seen = 0; fs_exp = 0; exp_en = 0;

    // Power-on reset
    repeat (5) @(posedge clk);
    #1;
    chk_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    // Two whole frames plus a little, checked on every clock
    for (int i = 0; i < 2 * 2 * NPIX + 2000; i++) step();
    chk("fs_count", 32'(fs_seen), 32'(fs_exp));
    chk("fs_count_frames", 32'(fs_seen), 2);

    // Advance into active video, then abort the frame with an async reset
    for (int i = 0; i < 2 * HT + 4 && !exp_en; i++) step();
    chk("pre_abort_active", 32'(exp_en), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("abort");
    repeat (5) @(posedge clk);
    #1;
    chk_reset_state("abort_hold");
    @(negedge clk);
    rst = 1'b0;
    k = 0; last_addr = '0;

    // Restart from (0,0): first lines re-read address 0 onward
    for (int i = 0; i < 4 * HT + 100; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
